// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection.
// A detected hazard stalls the upstream stages for one cycle, sends a bubble into EX and bumps a saturating counter.
module id_ex_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  id_valid_i,
    input  logic                  flush_i,
    input  logic                  id_mem_read_i,
    input  logic                  id_mem_to_reg_i,
    input  logic                  id_mem_write_i,
    input  logic                  id_reg_write_i,
    input  logic                  id_load_i,
    input  logic                  id_store_i,
    input  logic                  id_immd_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic [DATA_W-1:0]     id_rs1_data_i,
    input  logic [DATA_W-1:0]     id_rs2_data_i,
    input  logic [DATA_W-1:0]     id_imm_i,
    output logic                  stall_o,
    output logic                  ex_valid_o,
    output logic                  ex_mem_read_o,
    output logic                  ex_mem_to_reg_o,
    output logic                  ex_mem_write_o,
    output logic                  ex_reg_write_o,
    output logic                  ex_load_o,
    output logic                  ex_store_o,
    output logic                  ex_immd_o,
    output logic [REG_ADDR_W-1:0] ex_rs1_o,
    output logic [REG_ADDR_W-1:0] ex_rs2_o,
    output logic [REG_ADDR_W-1:0] ex_rd_o,
    output logic [DATA_W-1:0]     ex_rs1_data_o,
    output logic [DATA_W-1:0]     ex_rs2_data_o,
    output logic [DATA_W-1:0]     ex_imm_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);

    // Valid semantics: ex_valid_o marks a real instruction in EX; when it is 0
    // every control bit and field is 0. stall_o asks upstream to hold ID for this cycle.
    logic hz;
    logic rs1_match;
    logic rs2_match;
    logic take;

    always_comb begin
        rs1_match = (ex_rd_o == id_rs1_i);
        rs2_match = ~id_immd_i & (ex_rd_o == id_rs2_i);
        hz        = id_valid_i & ex_valid_o & ex_mem_read_o & (ex_rd_o != '0)
                    & (rs1_match | rs2_match);
        stall_o   = hz & ~flush_i & ~reset_i;
        take      = id_valid_i & ~flush_i & ~hz;
    end

    // Anything other than a clean capture zeroes EX, so a store's X mem_to_reg never leaks into a bubble.
    always_ff @(posedge clk_i) begin
        if (reset_i || !take) begin
            ex_valid_o      <= 1'b0;
            ex_mem_read_o   <= 1'b0;
            ex_mem_to_reg_o <= 1'b0;
            ex_mem_write_o  <= 1'b0;
            ex_reg_write_o  <= 1'b0;
            ex_load_o       <= 1'b0;
            ex_store_o      <= 1'b0;
            ex_immd_o       <= 1'b0;
            ex_rs1_o        <= '0;
            ex_rs2_o        <= '0;
            ex_rd_o         <= '0;
            ex_rs1_data_o   <= '0;
            ex_rs2_data_o   <= '0;
            ex_imm_o        <= '0;
        end else begin
            ex_valid_o      <= 1'b1;
            ex_mem_read_o   <= id_mem_read_i;
            ex_mem_to_reg_o <= id_mem_to_reg_i;
            ex_mem_write_o  <= id_mem_write_i;
            ex_reg_write_o  <= id_reg_write_i;
            ex_load_o       <= id_load_i;
            ex_store_o      <= id_store_i;
            ex_immd_o       <= id_immd_i;
            ex_rs1_o        <= id_rs1_i;
            ex_rs2_o        <= id_rs2_i;
            ex_rd_o         <= id_rd_i;
            ex_rs1_data_o   <= id_rs1_data_i;
            ex_rs2_data_o   <= id_rs2_data_i;
            ex_imm_o        <= id_imm_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_cnt_o <= '0;
        end else if (stall_o && (stall_cnt_o != {CNT_W{1'b1}})) begin
            stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a driver issues vectors and queues expected results, monitors compare them.
// A second instance with a 2-bit counter sees the same stimulus to exercise saturation.
module tb_id_ex_stage;

    typedef struct packed {
        logic        v;
        logic [6:0]  c;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } ex_t;

    // control order: mem_read, mem_to_reg, mem_write, reg_write, load, store, immd
    localparam logic [6:0] R_T = 7'b0001000;
    localparam logic [6:0] I_T = 7'b0001001;
    localparam logic [6:0] LD  = 7'b1101101;
    localparam logic [6:0] ST  = 7'b0010011;
    localparam logic [6:0] ALL = 7'b1111111;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic        flush;
    logic [6:0]  ctrl;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;

    logic        stall, stall2;
    logic        ex_valid, ex_mr, ex_mtr, ex_mw, ex_rw, ex_ld, ex_st, ex_im;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [31:0] ex_d1, ex_d2, ex_imm;
    logic [15:0] cnt;
    logic        u2_valid, u2_mr, u2_mtr, u2_mw, u2_rw, u2_ld, u2_st, u2_im;
    logic [4:0]  u2_rs1, u2_rs2, u2_rd;
    logic [31:0] u2_d1, u2_d2, u2_imm;
    logic [1:0]  cnt2;

    ex_t  exp_q[$];
    logic stall_q[$];
    int   checks = 0;
    int   errors = 0;

    id_ex_stage #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(16)) dut (
        .clk_i(clk), .reset_i(reset), .id_valid_i(id_valid), .flush_i(flush),
        .id_mem_read_i(ctrl[6]), .id_mem_to_reg_i(ctrl[5]), .id_mem_write_i(ctrl[4]),
        .id_reg_write_i(ctrl[3]), .id_load_i(ctrl[2]), .id_store_i(ctrl[1]), .id_immd_i(ctrl[0]),
        .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rd_i(rd),
        .id_rs1_data_i(d1), .id_rs2_data_i(d2), .id_imm_i(imm),
        .stall_o(stall), .ex_valid_o(ex_valid),
        .ex_mem_read_o(ex_mr), .ex_mem_to_reg_o(ex_mtr), .ex_mem_write_o(ex_mw),
        .ex_reg_write_o(ex_rw), .ex_load_o(ex_ld), .ex_store_o(ex_st), .ex_immd_o(ex_im),
        .ex_rs1_o(ex_rs1), .ex_rs2_o(ex_rs2), .ex_rd_o(ex_rd),
        .ex_rs1_data_o(ex_d1), .ex_rs2_data_o(ex_d2), .ex_imm_o(ex_imm),
        .stall_cnt_o(cnt)
    );

    id_ex_stage #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(2)) dut2 (
        .clk_i(clk), .reset_i(reset), .id_valid_i(id_valid), .flush_i(flush),
        .id_mem_read_i(ctrl[6]), .id_mem_to_reg_i(ctrl[5]), .id_mem_write_i(ctrl[4]),
        .id_reg_write_i(ctrl[3]), .id_load_i(ctrl[2]), .id_store_i(ctrl[1]), .id_immd_i(ctrl[0]),
        .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rd_i(rd),
        .id_rs1_data_i(d1), .id_rs2_data_i(d2), .id_imm_i(imm),
        .stall_o(stall2), .ex_valid_o(u2_valid),
        .ex_mem_read_o(u2_mr), .ex_mem_to_reg_o(u2_mtr), .ex_mem_write_o(u2_mw),
        .ex_reg_write_o(u2_rw), .ex_load_o(u2_ld), .ex_store_o(u2_st), .ex_immd_o(u2_im),
        .ex_rs1_o(u2_rs1), .ex_rs2_o(u2_rs2), .ex_rd_o(u2_rd),
        .ex_rs1_data_o(u2_d1), .ex_rs2_data_o(u2_d2), .ex_imm_o(u2_imm),
        .stall_cnt_o(cnt2)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout: run did not finish");
        $fatal(1, "timeout");
    end

    // Driver: applies one vector at the negedge. cap=1 means EX must hold this
    // vector after the edge, cap=0 means EX must be a zeroed bubble.
    task automatic step(input logic r, input logic f, input logic v, input logic [6:0] c,
                        input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad,
                        input logic e_stall, input logic cap,
                        input logic [15:0] e_cnt, input logic [1:0] e_cnt2);
        ex_t e;
        @(negedge clk);
        reset = r; flush = f; id_valid = v; ctrl = c;
        rs1 = a1; rs2 = a2; rd = ad;
        if (r) begin
            d1 = '1; d2 = '1; imm = '1;
        end else begin
            d1 = $urandom; d2 = $urandom; imm = $urandom_range(0, 4095);
        end
        e = '0;
        if (cap) begin
            e.v = 1'b1; e.c = c; e.rs1 = a1; e.rs2 = a2; e.rd = ad;
            e.d1 = d1; e.d2 = d2; e.imm = imm;
        end
        e.cnt  = e_cnt;
        e.cnt2 = e_cnt2;
        stall_q.push_back(e_stall);
        exp_q.push_back(e);
    endtask

    // scoreboard monitors
    initial begin : stall_mon
        int n;
        logic s;
        n = 0;
        forever begin
            @(negedge clk);
            #1;
            if (stall_q.size() > 0) begin
                s = stall_q.pop_front();
                checks++;
                if (stall !== s || stall2 !== s) begin
                    errors++;
                    $display("FAIL stall step %0d: got %0b/%0b expected %0b", n, stall, stall2, s);
                end
                n++;
            end
        end
    end

    initial begin : ex_mon
        int n;
        ex_t e, a;
        n = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {ex_valid, ex_mr, ex_mtr, ex_mw, ex_rw, ex_ld, ex_st, ex_im,
                     ex_rs1, ex_rs2, ex_rd, ex_d1, ex_d2, ex_imm, cnt, cnt2};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL ex_bundle step %0d: got %h expected %h", n, a, e);
                end
                n++;
            end
        end
    end

    initial begin
        reset = 1'b1; flush = 1'b0; id_valid = 1'b0; ctrl = '0;
        rs1 = '0; rs2 = '0; rd = '0; d1 = '0; d2 = '0; imm = '0;
        //    rst  fl   v    ctrl  rs1 rs2 rd  stall cap cnt cnt2
        // reset with every id_* input high
        step(1'b1, 1'b0, 1'b1, ALL, 31, 31, 31, 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 1'b1, ALL, 31, 31, 31, 1'b0, 1'b0, 0, 0);
        // R-type then I-type
        step(1'b0, 1'b0, 1'b1, R_T, 1, 2, 5, 1'b0, 1'b1, 0, 0);
        step(1'b0, 1'b0, 1'b1, I_T, 5, 0, 6, 1'b0, 1'b1, 0, 0);
        // load rd=3, dependent R-type on rs2: one stall, then the held R-type enters
        step(1'b0, 1'b0, 1'b1, LD,  2, 0, 3, 1'b0, 1'b1, 0, 0);
        step(1'b0, 1'b0, 1'b1, R_T, 1, 3, 7, 1'b1, 1'b0, 1, 1);
        step(1'b0, 1'b0, 1'b1, R_T, 1, 3, 7, 1'b0, 1'b1, 1, 1);
        // immediate form ignores rs2; rd=0 never hazards
        step(1'b0, 1'b0, 1'b1, LD,  2, 0, 3, 1'b0, 1'b1, 1, 1);
        step(1'b0, 1'b0, 1'b1, I_T, 1, 3, 9, 1'b0, 1'b1, 1, 1);
        step(1'b0, 1'b0, 1'b1, LD,  2, 0, 0, 1'b0, 1'b1, 1, 1);
        step(1'b0, 1'b0, 1'b1, R_T, 0, 0, 10, 1'b0, 1'b1, 1, 1);
        // flush coincides with a hazard: no stall, bubble, counter unchanged
        step(1'b0, 1'b0, 1'b1, LD,  2, 0, 4, 1'b0, 1'b1, 1, 1);
        step(1'b0, 1'b1, 1'b1, ST,  4, 5, 0, 1'b0, 1'b0, 1, 1);
        // invalid ID with all controls high still produces a clean bubble
        step(1'b0, 1'b0, 1'b0, ALL, 31, 31, 31, 1'b0, 1'b0, 1, 1);
        // chain of five load-use stalls: wide counter 2..6, 2-bit counter sticks at 3
        step(1'b0, 1'b0, 1'b1, LD,  1, 0, 8, 1'b0, 1'b1, 1, 1);
        step(1'b0, 1'b0, 1'b1, LD,  8, 0, 8, 1'b1, 1'b0, 2, 2);
        step(1'b0, 1'b0, 1'b1, LD,  8, 0, 8, 1'b0, 1'b1, 2, 2);
        step(1'b0, 1'b0, 1'b1, LD,  8, 0, 8, 1'b1, 1'b0, 3, 3);
        step(1'b0, 1'b0, 1'b1, LD,  8, 0, 8, 1'b0, 1'b1, 3, 3);
        step(1'b0, 1'b0, 1'b1, LD,  8, 0, 8, 1'b1, 1'b0, 4, 3);
        step(1'b0, 1'b0, 1'b1, LD,  8, 0, 8, 1'b0, 1'b1, 4, 3);
        step(1'b0, 1'b0, 1'b1, LD,  8, 0, 8, 1'b1, 1'b0, 5, 3);
        step(1'b0, 1'b0, 1'b1, LD,  8, 0, 8, 1'b0, 1'b1, 5, 3);
        step(1'b0, 1'b0, 1'b1, LD,  8, 0, 8, 1'b1, 1'b0, 6, 3);
        step(1'b0, 1'b0, 1'b1, LD,  8, 0, 8, 1'b0, 1'b1, 6, 3);
        step(1'b0, 1'b0, 1'b0, R_T, 8, 8, 1, 1'b0, 1'b0, 6, 3);
        // reset arrives while a hazard is pending
        step(1'b0, 1'b0, 1'b1, LD,  1, 0, 9, 1'b0, 1'b1, 6, 3);
        step(1'b1, 1'b0, 1'b1, R_T, 9, 2, 11, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b1, R_T, 9, 2, 11, 1'b0, 1'b1, 0, 0);
        begin : drain
            int k;
            k = 0;
            while ((exp_q.size() > 0 || stall_q.size() > 0) && k < 20) begin
                @(negedge clk);
                k++;
            end
            if (exp_q.size() > 0 || stall_q.size() > 0) begin
                checks++;
                errors++;
                $display("FAIL drain: %0d/%0d entries left, expected 0", exp_q.size(), stall_q.size());
            end
        end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
